// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM port arbiter: bus widths, the arbiter
// FSM encoding and the default starvation limit.
package sdram_pkg;

    localparam int unsigned ADDR_W = 22;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BE_W   = DATA_W / 8;

    localparam logic [2:0] STARVE_MAX_DEF = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sdram_arbiter.sv
// Two-master SDRAM arbiter: port 0 (display) has priority, port 1 (game logic)
// is granted after STARVE_MAX consecutive port-0 wins while it was waiting.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter logic [2:0] STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                CLK,
    input  logic                RST,

    input  logic [ADDR_W-1:0]   M0_ADDR,
    input  logic [BE_W-1:0]     M0_BYTEEN,
    input  logic                M0_WRITE,
    input  logic                M0_READ,
    input  logic [DATA_W-1:0]   M0_WRDATA,
    output logic [DATA_W-1:0]   M0_RDDATA,
    output logic                M0_WAITREQ,

    input  logic [ADDR_W-1:0]   M1_ADDR,
    input  logic [BE_W-1:0]     M1_BYTEEN,
    input  logic                M1_WRITE,
    input  logic                M1_READ,
    input  logic [DATA_W-1:0]   M1_WRDATA,
    output logic [DATA_W-1:0]   M1_RDDATA,
    output logic                M1_WAITREQ,

    output logic [ADDR_W-1:0]   S_ADDR,
    output logic [BE_W-1:0]     S_BYTEEN,
    output logic                S_WRITE,
    output logic                S_READ,
    output logic [DATA_W-1:0]   S_WRDATA,
    input  logic [DATA_W-1:0]   S_RDDATA,
    input  logic                S_WAITREQ,

    output logic [1:0]          GNT
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic [2:0] starve_cnt;
    logic [2:0] starve_nxt;
    logic       req0;
    logic       req1;

    assign req0 = M0_READ | M0_WRITE;
    assign req1 = M1_READ | M1_WRITE;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Arbitration happens only from IDLE, so every grant is separated by an idle cycle.
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        case (state)
            ST_IDLE: begin
                if (req0 && (!req1 || starve_cnt < STARVE_MAX)) begin
                    state_nxt = ST_G0;
                    if (req1 && starve_cnt < STARVE_MAX) begin
                        starve_nxt = starve_cnt + 3'd1;
                    end
                end else if (req1) begin
                    state_nxt  = ST_G1;
                    starve_nxt = '0;
                end
            end
            ST_G0, ST_G1: begin
                if (!S_WAITREQ) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        S_ADDR     = M0_ADDR;
        S_BYTEEN   = M0_BYTEEN;
        S_WRDATA   = M0_WRDATA;
        S_WRITE    = 1'b0;
        S_READ     = 1'b0;
        GNT        = 2'b00;
        M0_WAITREQ = 1'b1;
        M1_WAITREQ = 1'b1;
        case (state)
            ST_G0: begin
                S_WRITE    = M0_WRITE;
                S_READ     = M0_READ & ~M0_WRITE;
                GNT        = 2'b01;
                M0_WAITREQ = S_WAITREQ;
            end
            ST_G1: begin
                S_ADDR     = M1_ADDR;
                S_BYTEEN   = M1_BYTEEN;
                S_WRDATA   = M1_WRDATA;
                S_WRITE    = M1_WRITE;
                S_READ     = M1_READ & ~M1_WRITE;
                GNT        = 2'b10;
                M1_WAITREQ = S_WAITREQ;
            end
            default: ;
        endcase
    end

    assign M0_RDDATA = S_RDDATA;
    assign M1_RDDATA = S_RDDATA;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomised bench for sdram_arbiter: a behavioural SDRAM controller, two
// master drivers and a transaction-level ownership/scoreboard model.
module tb_sdram_arbiter;
    import sdram_pkg::*;

    localparam int unsigned INIT_CYC = 10000;
    localparam int unsigned STARVE   = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;

    logic [21:0] m0_addr = '0, m1_addr = '0;
    logic [1:0]  m0_be = '0, m1_be = '0;
    logic        m0_rd = 1'b0, m0_wr = 1'b0, m1_rd = 1'b0, m1_wr = 1'b0;
    logic [15:0] m0_wd = '0, m1_wd = '0;
    logic [15:0] M0_RDDATA, M1_RDDATA;
    logic        M0_WAITREQ, M1_WAITREQ;

    logic [21:0] S_ADDR;
    logic [1:0]  S_BYTEEN;
    logic        S_WRITE, S_READ;
    logic [15:0] S_WRDATA;
    logic [15:0] S_RDDATA = '0;
    logic        S_WAITREQ = 1'b1;
    logic [1:0]  GNT;

    sdram_arbiter #(.STARVE_MAX(3'd4)) dut (
        .CLK(CLK), .RST(RST),
        .M0_ADDR(m0_addr), .M0_BYTEEN(m0_be), .M0_WRITE(m0_wr), .M0_READ(m0_rd),
        .M0_WRDATA(m0_wd), .M0_RDDATA(M0_RDDATA), .M0_WAITREQ(M0_WAITREQ),
        .M1_ADDR(m1_addr), .M1_BYTEEN(m1_be), .M1_WRITE(m1_wr), .M1_READ(m1_rd),
        .M1_WRDATA(m1_wd), .M1_RDDATA(M1_RDDATA), .M1_WAITREQ(M1_WAITREQ),
        .S_ADDR(S_ADDR), .S_BYTEEN(S_BYTEEN), .S_WRITE(S_WRITE), .S_READ(S_READ),
        .S_WRDATA(S_WRDATA), .S_RDDATA(S_RDDATA), .S_WAITREQ(S_WAITREQ),
        .GNT(GNT)
    );

    always #10 CLK = ~CLK;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory contents before any write: a fixed function of the address.
    function automatic logic [15:0] init_word(input logic [21:0] a);
        return a[15:0] ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = wd[7:0];
        if (be[1]) r[15:8] = wd[15:8];
        return r;
    endfunction

    // Behavioural SDRAM controller memory and the bench's expected memory.
    logic [15:0] sd_mem  [int unsigned];
    logic [15:0] exp_mem [int unsigned];

    function automatic logic [15:0] sd_rd(input logic [21:0] a);
        return sd_mem.exists(int'(a)) ? sd_mem[int'(a)] : init_word(a);
    endfunction

    function automatic logic [15:0] exp_rd(input logic [21:0] a);
        return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : init_word(a);
    endfunction

    bit          c_busy = 1'b0;
    int unsigned c_left = 0;
    int unsigned init_left = INIT_CYC;
    bit          force_ref = 1'b0;

    task automatic ctrl_step();
        if (RST) begin
            S_WAITREQ = 1'b1;
            c_busy    = 1'b0;
            init_left = INIT_CYC;
            force_ref = 1'b0;
        end else if (!S_WAITREQ) begin
            S_WAITREQ = 1'b1;
        end else if (init_left != 0) begin
            init_left--;
        end else if (c_busy) begin
            if (c_left == 0) begin
                if (S_WRITE) sd_mem[int'(S_ADDR)] = merge(sd_rd(S_ADDR), S_WRDATA, S_BYTEEN);
                else         S_RDDATA = sd_rd(S_ADDR);
                S_WAITREQ = 1'b0;
                c_busy    = 1'b0;
            end else begin
                c_left--;
            end
        end else if (S_READ || S_WRITE) begin
            c_busy = 1'b1;
            c_left = $urandom_range(0, 3);
            if (force_ref)                    c_left += 12;
            else if ($urandom_range(0, 9) == 0) c_left += 8;
            force_ref = 1'b0;
        end
    endtask

    // Request levels as the DUT sees them at each rising edge.
    logic lat_r0 = 1'b0, lat_r1 = 1'b0, lat_sw = 1'b1, lat_rst = 1'b1;
    always @(posedge CLK) begin
        lat_r0  <= m0_rd | m0_wr;
        lat_r1  <= m1_rd | m1_wr;
        lat_sw  <= S_WAITREQ;
        lat_rst <= RST;
    end

    // Ownership model: who holds the bus (0 none, 1 port 0, 2 port 1) and how
    // many port-0 wins have gone by while port 1 was kept waiting.
    int          own = 0;
    int unsigned streak = 0;
    logic [1:0]  prev_gnt = 2'b00;
    int          gnt_log[$];
    int unsigned low0 = 0, low1 = 0;
    logic [15:0] last_rd [2];

    function automatic logic busy(input int p);
        return (p == 0) ? (m0_rd | m0_wr) : (m1_rd | m1_wr);
    endfunction

    task automatic start(input int p, input logic rd, input logic wr, input logic [21:0] a,
                         input logic [1:0] be, input logic [15:0] d);
        if (p == 0) begin
            m0_rd = rd; m0_wr = wr; m0_addr = a; m0_be = be; m0_wd = d;
        end else begin
            m1_rd = rd; m1_wr = wr; m1_addr = a; m1_be = be; m1_wd = d;
        end
    endtask

    task automatic start_rand(input int p, input bit rd_only);
        int unsigned op;
        logic [21:0] a;
        op = rd_only ? 0 : $urandom_range(0, 2);
        if ($urandom_range(0, 7) == 0) a = 22'h3FFFF0 + 22'($urandom_range(0, 15));
        else                           a = 22'($urandom_range(0, 31));
        start(p, op != 1, op != 0, a, 2'($urandom_range(0, 3)), 16'($urandom));
    endtask

    task automatic complete(input int p);
        logic [21:0] a;
        logic [1:0]  be;
        logic [15:0] wd, rdv;
        logic        wr;
        if (p == 0) begin a = m0_addr; be = m0_be; wd = m0_wd; wr = m0_wr; rdv = M0_RDDATA; end
        else        begin a = m1_addr; be = m1_be; wd = m1_wd; wr = m1_wr; rdv = M1_RDDATA; end
        if (wr) exp_mem[int'(a)] = merge(exp_rd(a), wd, be);
        else    chk(p == 0 ? "m0_rddata" : "m1_rddata", 64'(rdv), 64'(exp_rd(a)));
        last_rd[p] = rdv;
        start(p, 1'b0, 1'b0, a, be, wd);
    endtask

    task automatic monitor();
        logic [1:0] exp_gnt;
        if (RST || lat_rst) begin
            own = 0; streak = 0;
        end else if (own == 0) begin
            if (lat_r0 && lat_r1) begin
                if (streak < STARVE) begin own = 1; streak++; end
                else                 begin own = 2; streak = 0; end
            end else if (lat_r0) begin
                own = 1;
            end else if (lat_r1) begin
                own = 2; streak = 0;
            end
        end else if (!lat_sw) begin
            own = 0;
        end
        exp_gnt = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
        chk("gnt", 64'(GNT), 64'(exp_gnt));
        chk("gnt_onehot0", 64'($onehot0(GNT)), 64'(1));
        if (GNT == 2'b00) chk("idle_rw", 64'({S_READ, S_WRITE}), 64'(0));
        chk("wait_excl", 64'(!M0_WAITREQ && !M1_WAITREQ), 64'(0));
        chk("m0_wait", 64'(M0_WAITREQ), 64'(own == 1 ? S_WAITREQ : 1'b1));
        chk("m1_wait", 64'(M1_WAITREQ), 64'(own == 2 ? S_WAITREQ : 1'b1));
        chk("rd_route", 64'({M0_RDDATA, M1_RDDATA}), 64'({S_RDDATA, S_RDDATA}));
        if (own == 2) begin
            chk("s_cmd1", 64'({S_ADDR, S_BYTEEN, S_WRDATA, S_WRITE, S_READ}),
                64'({m1_addr, m1_be, m1_wd, m1_wr, m1_rd & ~m1_wr}));
        end else begin
            chk("s_fields0", 64'({S_ADDR, S_BYTEEN, S_WRDATA}), 64'({m0_addr, m0_be, m0_wd}));
            if (own == 1) chk("s_rw0", 64'({S_WRITE, S_READ}), 64'({m0_wr, m0_rd & ~m0_wr}));
        end
        if (!M0_WAITREQ) low0++;
        if (!M1_WAITREQ) low1++;
        if (prev_gnt == 2'b00 && GNT != 2'b00) gnt_log.push_back(GNT == 2'b10 ? 1 : 0);
        prev_gnt = GNT;
        if (own == 1 && !S_WAITREQ) complete(0);
        if (own == 2 && !S_WAITREQ) complete(1);
    endtask

    task automatic tick();
        @(negedge CLK);
        ctrl_step();
        #2;
        monitor();
    endtask

    task automatic wait_idle(input int p, input int unsigned bound, input string tag);
        for (int unsigned i = 0; i < bound && busy(p); i++) tick();
        chk(tag, 64'(busy(p)), 64'(0));
        if (busy(p)) start(p, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        int exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int unsigned waited;

        repeat (3) tick();
        chk("rst_out", 64'({GNT, S_READ, S_WRITE, M0_WAITREQ, M1_WAITREQ}), 64'(6'b000011));
        RST = 1'b0;
        repeat (INIT_CYC + 5) tick();

        // Port 0 read alone.
        start(0, 1'b1, 1'b0, 22'h000100, 2'b11, 16'h0000);
        low0 = 0; low1 = 0;
        tick();
        chk("t032_gnt", 64'(GNT), 64'(2'b01));
        wait_idle(0, 100, "t032_timeout");
        repeat (3) tick();
        chk("t032_m0_low", 64'(low0), 64'(1));
        chk("t032_m1_low", 64'(low1), 64'(0));

        // Port 1 byte write at the top address, read back through port 0.
        start(1, 1'b0, 1'b1, 22'h3FFFFF, 2'b01, 16'hBEEF);
        tick();
        chk("t033_gnt", 64'(GNT), 64'(2'b10));
        chk("t033_s_addr", 64'(S_ADDR), 64'(22'h3FFFFF));
        chk("t033_s_be", 64'(S_BYTEEN), 64'(2'b01));
        wait_idle(1, 100, "t033_wr_timeout");
        start(0, 1'b1, 1'b0, 22'h3FFFFF, 2'b11, 16'h0000);
        wait_idle(0, 100, "t033_rd_timeout");
        chk("t033_low_byte", 64'(last_rd[0][7:0]), 64'(8'hEF));

        // Port 1 request stretched by a refresh.
        force_ref = 1'b1;
        low1 = 0;
        start(1, 1'b1, 1'b0, 22'h000005, 2'b11, 16'h0000);
        wait_idle(1, 100, "t035_timeout");
        repeat (3) tick();
        chk("t035_m1_low", 64'(low1), 64'(1));

        // Both ports requesting back to back.
        gnt_log.delete();
        for (int unsigned i = 0; i < 400 && gnt_log.size() < 10; i++) begin
            if (!busy(0)) start_rand(0, 1'b1);
            if (!busy(1)) start_rand(1, 1'b1);
            tick();
        end
        chk("t034_count", 64'(gnt_log.size() >= 10), 64'(1));
        for (int i = 0; i < 10 && i < gnt_log.size(); i++) begin
            chk($sformatf("t034_seq%0d", i), 64'(gnt_log[i]), 64'(exp_seq[i]));
        end
        wait_idle(0, 100, "t034_drain0");
        wait_idle(1, 100, "t034_drain1");

        // Random traffic from both masters.
        for (int unsigned i = 0; i < 3000; i++) begin
            if (!busy(0) && $urandom_range(0, 3) == 0) start_rand(0, 1'b0);
            if (!busy(1) && $urandom_range(0, 2) == 0) start_rand(1, 1'b0);
            tick();
        end
        wait_idle(0, 100, "rand_drain0");
        wait_idle(1, 100, "rand_drain1");

        // Reset in the middle of a port-1 grant.
        force_ref = 1'b1;
        start(1, 1'b1, 1'b0, 22'h000007, 2'b11, 16'h0000);
        for (int unsigned i = 0; i < 20 && GNT != 2'b10; i++) tick();
        chk("t036_in_g1", 64'(GNT), 64'(2'b10));
        RST = 1'b1;
        #1;
        chk("t036_rst_out", 64'({GNT, S_READ, S_WRITE, M0_WAITREQ, M1_WAITREQ}), 64'(6'b000011));
        start(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) tick();
        RST = 1'b0;
        start(0, 1'b1, 1'b0, 22'h000100, 2'b11, 16'h0000);
        waited = 0;
        while (busy(0) && waited < INIT_CYC + 100) begin
            tick();
            waited++;
        end
        chk("t036_served", 64'(busy(0)), 64'(0));
        chk("t036_init_wait", 64'(waited >= INIT_CYC), 64'(1));
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
